pong_match_controller: RTL and testbench

Match-level sequencer for the Pong datapath. It owns the game state (paused, serve, rally, goal, win), the two score counters and the pause key. It gates the ball/paddle update logic with a run enable, requests ball re-centering before each serve, and drives the LED animation. It sits between the board keys and the ball/paddle datapath in the top level, clocked by CLOCK_25 and advanced by the ball-rate tick.

---
 rtl/pong_match_controller.sv | 199 +++++++++++++++++++
 tb/tb_pong_match_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pong_match_controller.sv
// Match-level sequencer for Pong: game state, scores, pause key handling,
// datapath run/serve gating and the LED animation.
module pong_match_controller #(
  parameter int WIN_SCORE     = 7,
  parameter int SERVE_TICKS   = 32,
  parameter int GOAL_TICKS    = 64,
  parameter int WIN_TICKS     = 256,
  parameter int LOCKOUT_TICKS = 4
) (
  input  logic       CLOCK_25,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       pause_key_n,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       run,
  output logic       ball_reset,
  output logic       serve_left,
  output logic [2:0] score_1,
  output logic [2:0] score_2,
  output logic       goal_1,
  output logic       goal_2,
  output logic       win_1,
  output logic       win_2,
  output logic [7:0] led
);

  localparam logic [2:0] S_PAUSED = 3'd0;
  localparam logic [2:0] S_SERVE  = 3'd1;
  localparam logic [2:0] S_PLAY   = 3'd2;
  localparam logic [2:0] S_GOAL   = 3'd3;
  localparam logic [2:0] S_WIN    = 3'd4;

  logic [2:0] st, st_n, resume, res_n;
  logic [8:0] cnt, cnt_n, lock, lock_n;
  logic [2:0] s1_n, s2_n;
  logic       sl_n, g1_n, g2_n, w1_n, w2_n;
  logic [7:0] led_n;
  logic       k1, k2, k3, press, accept, miss_any;

  // Key sync chain idles high (released); press is the synced falling edge.
  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      k1 <= 1'b1;
      k2 <= 1'b1;
      k3 <= 1'b1;
    end else begin
      k1 <= pause_key_n;
      k2 <= k1;
      k3 <= k2;
    end
  end

  assign press    = k3 & ~k2;
  assign miss_any = miss_left | miss_right;
  // A press that collides with a miss in PLAY is swallowed and does not arm lockout.
  assign accept   = press && (lock == 9'd0) &&
                    ((st == S_PAUSED) || (st == S_SERVE) || ((st == S_PLAY) && !miss_any));

  always_comb begin
    lock_n = lock;
    if (accept)
      lock_n = 9'(LOCKOUT_TICKS);
    else if (tick && lock != 9'd0)
      lock_n = lock - 9'd1;
  end

  always_comb begin
    st_n  = st;
    res_n = resume;
    cnt_n = cnt;
    s1_n  = score_1;
    s2_n  = score_2;
    sl_n  = serve_left;
    g1_n  = goal_1;
    g2_n  = goal_2;
    w1_n  = win_1;
    w2_n  = win_2;
    case (st)
      S_PAUSED: if (accept) st_n = resume;
      S_SERVE: begin
        if (accept) begin
          res_n = S_SERVE;
          st_n  = S_PAUSED;
        end else if (tick) begin
          if (cnt == 9'(SERVE_TICKS - 1)) st_n = S_PLAY;
          else cnt_n = cnt + 9'd1;
        end
      end
      S_PLAY: begin
        if (miss_left && miss_right) begin
          st_n = S_SERVE;
        end else if (miss_right) begin
          s1_n = score_1 + 3'd1;
          sl_n = 1'b0;
          if (score_1 == 3'(WIN_SCORE - 1)) begin
            st_n = S_WIN;
            w1_n = 1'b1;
          end else begin
            st_n = S_GOAL;
            g1_n = 1'b1;
          end
        end else if (miss_left) begin
          s2_n = score_2 + 3'd1;
          sl_n = 1'b1;
          if (score_2 == 3'(WIN_SCORE - 1)) begin
            st_n = S_WIN;
            w2_n = 1'b1;
          end else begin
            st_n = S_GOAL;
            g2_n = 1'b1;
          end
        end else if (accept) begin
          res_n = S_PLAY;
          st_n  = S_PAUSED;
        end
      end
      S_GOAL: begin
        if (tick) begin
          if (cnt == 9'(GOAL_TICKS - 1)) st_n = S_SERVE;
          else cnt_n = cnt + 9'd1;
        end
      end
      S_WIN: begin
        if (tick) begin
          if (cnt == 9'(WIN_TICKS - 1)) begin
            s1_n  = 3'd0;
            s2_n  = 3'd0;
            sl_n  = 1'b0;
            res_n = S_SERVE;
            st_n  = S_PAUSED;
          end else begin
            cnt_n = cnt + 9'd1;
          end
        end
      end
      default: st_n = S_PAUSED;
    endcase
    if (st_n != st) cnt_n = 9'd0;
    if (st_n != S_GOAL) begin
      g1_n = 1'b0;
      g2_n = 1'b0;
    end
    if (st_n != S_WIN) begin
      w1_n = 1'b0;
      w2_n = 1'b0;
    end
  end

  always_comb begin
    led_n = 8'h00;
    case (st_n)
      S_PAUSED: led_n = 8'b1000_0001;
      S_GOAL: begin
        if (st != S_GOAL)  led_n = g1_n ? 8'b0000_0001 : 8'b1000_0000;
        else if (tick)     led_n = goal_1 ? {led[6:0], led[7]} : {led[0], led[7:1]};
        else               led_n = led;
      end
      // 8-tick blink: counter bit 3 selects the dark half.
      S_WIN:   led_n = cnt_n[3] ? 8'h00 : 8'hFF;
      default: led_n = 8'h00;
    endcase
  end

  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      st         <= S_PAUSED;
      resume     <= S_SERVE;
      cnt        <= 9'd0;
      lock       <= 9'd0;
      run        <= 1'b0;
      ball_reset <= 1'b0;
      serve_left <= 1'b0;
      score_1    <= 3'd0;
      score_2    <= 3'd0;
      goal_1     <= 1'b0;
      goal_2     <= 1'b0;
      win_1      <= 1'b0;
      win_2      <= 1'b0;
      led        <= 8'b1000_0001;
    end else begin
      st         <= st_n;
      resume     <= res_n;
      cnt        <= cnt_n;
      lock       <= lock_n;
      run        <= (st_n == S_PLAY);
      ball_reset <= (st_n == S_SERVE);
      serve_left <= sl_n;
      score_1    <= s1_n;
      score_2    <= s2_n;
      goal_1     <= g1_n;
      goal_2     <= g2_n;
      win_1      <= w1_n;
      win_2      <= w2_n;
      led        <= led_n;
    end
  end

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed bench for pong_match_controller: serve, goal, win, double miss,
// pause lockout and asynchronous reset mid-animation.
module tb_pong_match_controller;

  logic       clk = 1'b0;
  logic       reset_n, tick, pause_key_n, miss_left, miss_right;
  logic       run, ball_reset, serve_left, goal_1, goal_2, win_1, win_2;
  logic [2:0] score_1, score_2;
  logic [7:0] led;
  int         vectors = 0;
  int         miscompares = 0;

  always #20 clk = ~clk;

  pong_match_controller dut (
    .CLOCK_25   (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .pause_key_n(pause_key_n),
    .miss_left  (miss_left),
    .miss_right (miss_right),
    .run        (run),
    .ball_reset (ball_reset),
    .serve_left (serve_left),
    .score_1    (score_1),
    .score_2    (score_2),
    .goal_1     (goal_1),
    .goal_2     (goal_2),
    .win_1      (win_1),
    .win_2      (win_2),
    .led        (led)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic press_key();
    pause_key_n = 1'b0;
    cyc(4);
    pause_key_n = 1'b1;
    cyc(4);
  endtask

  task automatic miss(input logic l, input logic r);
    miss_left  = l;
    miss_right = r;
    @(negedge clk);
    miss_left  = 1'b0;
    miss_right = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; tick = 1'b0; pause_key_n = 1'b1; miss_left = 1'b0; miss_right = 1'b0;
    cyc(2);
    chk("rst_run", run, 8'd0);
    chk("rst_ball_reset", ball_reset, 8'd0);
    chk("rst_serve_left", serve_left, 8'd0);
    chk("rst_score_1", score_1, 8'd0);
    chk("rst_score_2", score_2, 8'd0);
    chk("rst_goal_win", {goal_1, goal_2, win_1, win_2}, 8'd0);
    chk("rst_led", led, 8'h81);
    reset_n = 1'b1;
    cyc(1);

    // First serve
    press_key();
    chk("serve_ball_reset", ball_reset, 8'd1);
    chk("serve_led", led, 8'h00);
    ticks(31);
    chk("serve_31_run", run, 8'd0);
    ticks(1);
    chk("play_run", run, 8'd1);
    chk("play_ball_reset", ball_reset, 8'd0);

    // Player 1 scores
    miss(1'b0, 1'b1);
    chk("goal1_score_1", score_1, 8'd1);
    chk("goal1_flag", goal_1, 8'd1);
    chk("goal1_run", run, 8'd0);
    chk("goal1_led0", led, 8'h01);
    ticks(1);
    chk("goal1_led1", led, 8'h02);
    ticks(62);
    chk("goal1_led63", led, 8'h80);
    chk("goal1_still", goal_1, 8'd1);
    ticks(1);
    chk("goal1_to_serve", ball_reset, 8'd1);
    chk("goal1_serve_left", serve_left, 8'd0);
    chk("goal1_cleared", goal_1, 8'd0);
    ticks(32);

    // Player 2 scores: first goal checked, then five more to reach 6
    miss(1'b1, 1'b0);
    chk("goal2_score_2", score_2, 8'd1);
    chk("goal2_flag", goal_2, 8'd1);
    chk("goal2_serve_left", serve_left, 8'd1);
    chk("goal2_led0", led, 8'h80);
    ticks(1);
    chk("goal2_led1", led, 8'h40);
    ticks(63 + 32);
    for (int i = 0; i < 5; i++) begin
      miss(1'b1, 1'b0);
      ticks(64 + 32);
    end
    chk("pre_win_score_2", score_2, 8'd6);
    chk("pre_win_run", run, 8'd1);

    // Winning point
    miss(1'b1, 1'b0);
    chk("win_score_2", score_2, 8'd7);
    chk("win_flag", win_2, 8'd1);
    chk("win_run", run, 8'd0);
    chk("win_led0", led, 8'hFF);
    ticks(7);
    chk("win_led7", led, 8'hFF);
    ticks(1);
    chk("win_led8", led, 8'h00);
    ticks(8);
    chk("win_led16", led, 8'hFF);
    ticks(239);
    chk("win_led255", led, 8'h00);
    chk("win_still", win_2, 8'd1);
    ticks(1);
    chk("post_win_score_1", score_1, 8'd0);
    chk("post_win_score_2", score_2, 8'd0);
    chk("post_win_led", led, 8'h81);
    chk("post_win_flag", win_2, 8'd0);
    chk("post_win_serve_left", serve_left, 8'd0);
    chk("post_win_ball_reset", ball_reset, 8'd0);

    // Resume goes to SERVE after a win
    press_key();
    chk("rematch_serve", ball_reset, 8'd1);
    ticks(32);
    chk("rematch_play", run, 8'd1);

    // Simultaneous misses re-serve with no score
    miss(1'b1, 1'b1);
    chk("dbl_score_1", score_1, 8'd0);
    chk("dbl_score_2", score_2, 8'd0);
    chk("dbl_serve", ball_reset, 8'd1);
    chk("dbl_flags", {goal_1, goal_2, win_1, win_2}, 8'd0);
    ticks(32);
    chk("dbl_play", run, 8'd1);

    // Pause from PLAY with lockout
    press_key();
    chk("pause_run", run, 8'd0);
    chk("pause_led", led, 8'h81);
    ticks(2);
    press_key();
    chk("lockout_ignored", run, 8'd0);
    ticks(2);
    press_key();
    chk("resume_run", run, 8'd1);
    chk("resume_no_serve", ball_reset, 8'd0);

    // Asynchronous reset mid-GOAL
    miss(1'b0, 1'b1);
    chk("goal_pre_rst", goal_1, 8'd1);
    ticks(3);
    reset_n = 1'b0;
    #1;
    chk("async_goal_1", goal_1, 8'd0);
    chk("async_score_1", score_1, 8'd0);
    chk("async_led", led, 8'h81);
    chk("async_run_ball", {run, ball_reset}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
